// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start-bit detect, mid-bit sampling with a
// programmable divisor, LSB-first deserialisation and a single-entry output register.
module serial_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  d_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  localparam logic [4:0]           LAST_IDX = 5'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

  state_e                state_q;
  logic                  d_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic [4:0]            idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  ovr_q;

  logic [DIV_WIDTH-1:0]  div_eff_d;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  fall_d;
  logic                  cnt_zero_d;
  logic                  stop_ok_d;
  logic                  buf_free_d;

  assign div_eff_d  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign fall_d     = en_i && d_q && !d_i;
  assign cnt_zero_d = (cnt_q == '0);
  // Shift in from the top so after DATA_WIDTH samples bit 0 holds the first data bit.
  assign shift_d    = (shift_q >> 1) | (DATA_WIDTH'(d_i) << (DATA_WIDTH - 1));
  assign stop_ok_d  = en_i && (state_q == STOP) && cnt_zero_d && d_i;
  assign buf_free_d = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      d_q     <= 1'b1;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      d_q     <= 1'b1;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;
      // A commit into a full buffer keeps the old word and reports the loss.
      if (stop_ok_d) begin
        if (buf_free_d) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
      if (en_i) begin
        d_q <= d_i;
        case (state_q)
          IDLE: begin
            if (fall_d) begin
              div_q   <= div_eff_d;
              cnt_q   <= (div_eff_d >> 1) - ONE;
              state_q <= START;
            end
          end
          START: begin
            if (cnt_zero_d) begin
              if (!d_i) begin
                cnt_q   <= div_q - ONE;
                idx_q   <= '0;
                shift_q <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          DATA: begin
            if (cnt_zero_d) begin
              shift_q <= shift_d;
              cnt_q   <= div_q - ONE;
              idx_q   <= idx_q + 5'd1;
              if (idx_q == LAST_IDX) state_q <= STOP;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          STOP: begin
            if (cnt_zero_d) begin
              if (d_i) begin
                state_q <= IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BRK;
              end
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          BRK: begin
            if (d_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frames are generated from a bit list, expected words
// go into a queue, and a negedge monitor checks every handshake and pulse.
module tb_serial_frame_rx;
  logic        clk_i = 1'b0;
  logic        rst_ni, clr_i, en_i, d_i, ready_i;
  logic [15:0] div_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, overrun_o, busy_o;

  serial_frame_rx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .en_i(en_i), .div_i(div_i),
    .d_i(d_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int exp_ferr = 0, exp_ovr = 0, ferr_cnt = 0, ovr_cnt = 0;
  int rise_cyc = -1, ferr_cyc = -1, ovr_cyc = -1;
  bit rnd_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words on handshake, tracks pulses and hold stability.
  logic pv = 0, pr = 0, pc = 0, prst = 0, pf = 0, po = 0;
  logic [7:0] pd = 0;
  always @(negedge clk_i) begin
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word actual=%0h required=none", data_o);
      end else begin
        check("word", int'(data_o), int'(exp_q.pop_front()));
      end
    end
    if (rst_ni && prst && !pc && pv && !pr) begin
      check("hold_valid", int'(valid_o), 1);
      check("hold_data", int'(data_o), int'(pd));
    end
    if (valid_o && !pv) rise_cyc = cyc;
    if (frame_err_o) begin
      ferr_cnt++;
      ferr_cyc = cyc;
      check("ferr_width", int'(pf), 0);
    end
    if (overrun_o) begin
      ovr_cnt++;
      ovr_cyc = cyc;
      check("ovr_width", int'(po), 0);
    end
    if (frame_err_o || overrun_o) check("pulse_excl", int'(frame_err_o && overrun_o), 0);
    pv = valid_o; pr = ready_i; pc = clr_i; prst = rst_ni; pd = data_o;
    pf = frame_err_o; po = overrun_o;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (rnd_mode) ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Drives start, 8 data bits LSB-first and stop, each lasting max(d,2) cycles.
  // A stall of stall_len en_i-low cycles is inserted at frame cycle stall_at.
  task automatic send_frame(input int d, input logic [7:0] b, input logic stopb,
                            input int stall_at, input int stall_len, output int t0);
    logic [9:0] bits;
    int deff, n;
    bits = {stopb, b, 1'b0};
    deff = (d < 2) ? 2 : d;
    n = 0;
    div_i = 16'(d);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      d_i = bits[i];
      for (int j = 0; j < deff; j++) begin
        if (n == stall_at) begin
          en_i = 1'b0;
          tick(stall_len);
          en_i = 1'b1;
        end
        tick();
        n++;
        if (n == 1) div_i = 16'($urandom);
      end
    end
  endtask

  int t0, t0b, fc, w, rd;
  logic [7:0] rb;
  logic rs;

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; en_i = 1'b1; d_i = 1'b1; div_i = 16'd4; ready_i = 1'b1;
    tick(3);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_pulses", int'({frame_err_o, overrun_o}), 0);
    rst_ni = 1'b1;
    tick(3);

    // Basic receive
    exp_q.push_back(8'hA5);
    send_frame(4, 8'hA5, 1'b1, -1, 0, t0);
    tick(2);
    check("basic_rise", rise_cyc, t0 + 39);

    // False start
    fc = ferr_cnt;
    div_i = 16'd8; d_i = 1'b0; t0 = cyc;
    tick(2);
    check("fs_busy_hi", int'(busy_o), 1);
    d_i = 1'b1;
    tick(10);
    check("fs_busy_lo", int'(busy_o), 0);
    check("fs_no_ferr", ferr_cnt, fc);

    // Framing error then a good frame
    fc = ferr_cnt;
    exp_ferr++;
    send_frame(4, 8'h3C, 1'b0, -1, 0, t0);
    tick(10);
    check("fe_cyc", ferr_cyc, t0 + 39);
    check("fe_count", ferr_cnt, fc + 1);
    check("fe_busy", int'(busy_o), 1);
    check("fe_valid", int'(valid_o), 0);
    d_i = 1'b1;
    tick(2);
    check("fe_busy_lo", int'(busy_o), 0);
    exp_q.push_back(8'h81);
    send_frame(4, 8'h81, 1'b1, -1, 0, t0);
    tick(2);
    check("fe_next_rise", rise_cyc, t0 + 39);

    // Overrun
    ready_i = 1'b0;
    tick();
    exp_q.push_back(8'h11);
    send_frame(4, 8'h11, 1'b1, -1, 0, t0);
    send_frame(4, 8'h22, 1'b1, -1, 0, t0b);
    exp_ovr++;
    tick(2);
    check("ovr_cyc", ovr_cyc, t0b + 39);
    check("ovr_valid", int'(valid_o), 1);
    check("ovr_data", int'(data_o), 8'h11);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    tick();
    check("ovr_drop_valid", int'(valid_o), 0);
    check("ovr_keep_data", int'(data_o), 8'h11);
    ready_i = 1'b1;
    tick(2);

    // Odd divisor, stall, and divisor below minimum
    exp_q.push_back(8'h5A);
    send_frame(5, 8'h5A, 1'b1, -1, 0, t0);
    tick(2);
    check("div5_rise", rise_cyc, t0 + 48);
    exp_q.push_back(8'h5A);
    send_frame(5, 8'h5A, 1'b1, 20, 3, t0);
    tick(2);
    check("stall_rise", rise_cyc, t0 + 51);
    exp_q.push_back(8'h5A);
    send_frame(1, 8'h5A, 1'b1, -1, 0, t0);
    tick(2);
    check("div1_rise", rise_cyc, t0 + 20);

    // Async reset mid-DATA
    div_i = 16'd4; d_i = 1'b0;
    tick(4);
    d_i = 1'b1;
    tick(6);
    rst_ni = 1'b0;
    #2;
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    tick();
    rst_ni = 1'b1;
    tick(3);

    // Clear mid-DATA with a word buffered
    ready_i = 1'b0;
    send_frame(4, 8'h33, 1'b1, -1, 0, t0);
    tick(2);
    check("clr_buffered", int'(valid_o), 1);
    div_i = 16'd4; d_i = 1'b0;
    tick(4);
    d_i = 1'b1;
    tick(6);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_valid", int'(valid_o), 0);
    check("clr_data", int'(data_o), 0);
    check("clr_busy", int'(busy_o), 0);
    ready_i = 1'b1;
    tick(2);
    exp_q.push_back(8'hFF);
    send_frame(4, 8'hFF, 1'b1, -1, 0, t0);
    tick(2);
    check("ff_rise", rise_cyc, t0 + 39);

    // Randomised frames with random consumer back-pressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rd = $urandom_range(0, 7);
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      if (rs) exp_q.push_back(rb);
      else exp_ferr++;
      send_frame(rd, rb, rs, -1, 0, t0);
      if (!rs) begin
        tick($urandom_range(1, 5));
        d_i = 1'b1;
        tick(2);
      end else begin
        tick($urandom_range(0, 3));
      end
    end
    rnd_mode = 1'b0;
    ready_i = 1'b1;

    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("drain", exp_q.size(), 0);
    tick(3);
    check("ferr_total", ferr_cnt, exp_ferr);
    check("ovr_total", ovr_cnt, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Asynchronous serial frame receiver. It sits directly downstream of the serial line deglitcher and consumes its filtered, idle-high line output. The block detects the start bit and samples each bit at mid-bit using a programmable cycle divisor. It deserialises the frame LSB-first, checks the stop bit, and hands each word to the consumer through a single-entry valid/ready output register.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..16).
DIV_WIDTH, 16, width of the bit-period divisor input.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
clr_i  input  1  synchronous clear, active high
en_i  input  1  enable; low freezes line sampling, FSM and counters
div_i  input  DIV_WIDTH  clock cycles per bit; latched at start-bit detection; values <2 treated as 2
d_i  input  1  deglitched serial line, idle high
data_o  output  DATA_WIDTH  received word
valid_o  output  1  data_o holds an unconsumed word
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: completed word dropped because the buffer was full
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni low, async) and clr_i (sync, priority over en_i):
  - FSM to IDLE; line history register d_q to 1; counters to 0; shift register to 0.
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Any buffered word is discarded.
- d_q registers d_i every enabled cycle. A falling edge is d_q=1 && d_i=0 while en_i=1.
- FSM states:
  - IDLE: on falling edge, latch D=max(div_i,2), load bit counter to floor(D/2)-1, go to START.
  - START: count down each enabled cycle. At 0, sample d_i. If low, reload D-1, clear bit index, go to DATA. If high, treat as false start and return to IDLE with no pulse.
  - DATA: at counter 0, shift d_i into bit[index], LSB first, and reload D-1. After bit DATA_WIDTH-1, go to STOP.
  - STOP: at counter 0, sample d_i.
    - If high: commit the word and go to IDLE.
    - If low: pulse frame_err_o, discard the word, go to BREAK.
  - BREAK: wait until d_i=1, then go to IDLE. A new falling edge is only recognised from IDLE.
- Timing:
  - Edge-detect cycle = t0.
  - Start sample at t0+floor(D/2).
  - Data bit k sampled at t0+floor(D/2)+(k+1)*D.
  - Stop bit sampled at t0+floor(D/2)+(DATA_WIDTH+1)*D.
  - valid_o and data_o update in the cycle after the stop sample.
  - Each en_i-low cycle delays all later events by one cycle.
- Output buffer:
  - Commit when the buffer is free: valid_o=0, or valid_o && ready_i in the same cycle. Load data_o and set valid_o=1.
  - Commit when the buffer is full (valid_o=1, ready_i=0): keep the old word, drop the new one, pulse overrun_o.
  - Handshake: valid_o drops the cycle after valid_o && ready_i unless a new commit occurs in that same cycle.
  - data_o is stable while valid_o=1 and ready_i=0.
  - The handshake operates regardless of en_i.
- Both pulses last exactly one cycle. frame_err_o and overrun_o are never asserted in the same cycle.
- div_i changes mid-frame have no effect until the next start-bit detection.

Test Plan:
- Basic receive, DIV=4, frame 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop), ready_i=1 -> valid_o pulses one cycle with data_o=0xA5, stop sample at t0+38, valid_o at t0+39, no error pulses.
- False start, DIV=8, d_i low 2 cycles then high -> START sample at t0+4 reads 1, FSM back to IDLE, no valid_o, no frame_err_o.
- Framing error, DIV=4, byte 0x3C with stop bit 0, line held low 10 more cycles -> frame_err_o single pulse at stop sample+1, valid_o stays 0, busy_o stays 1 until d_i returns high, next frame 0x81 received correctly.
- Overrun, ready_i=0, two back-to-back frames 0x11 then 0x22 -> data_o=0x11 held, overrun_o pulses once at second commit; then ready_i=1 for one cycle -> valid_o falls, data_o unchanged.
- Stall and odd divisor, DIV=5 (div_i=1 also checked, treated as 2), en_i low 3 cycles in mid-DATA -> byte 0x5A still received, valid_o exactly 3 cycles later than the unstalled case.
- Reset and clear mid-frame: assert rst_ni low mid-DATA, then separately clr_i mid-DATA with a word buffered -> all outputs 0, buffered word lost, next frame 0xFF received normally.
